// File: rtl/core_seq_if.sv
// core_seq_if: control inputs and status outputs of the instruction sequencer
interface core_seq_if #(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32
);
    logic                  stall;
    logic                  branch_taken;
    logic [XLEN-1:0]       branch_target;
    logic                  trap_req;
    logic [XLEN-1:0]       trap_vector;
    logic                  halt_req;
    logic                  resume;
    logic [2:0]            stage;
    logic [NUM_STAGES-1:0] stage_oh;
    logic [XLEN-1:0]       pc;
    logic                  wb_en;
    logic                  retire;
    logic                  misaligned;
    logic                  halted;
    logic [CNT_W-1:0]      instret;
    logic [CNT_W-1:0]      cycles;

    modport master (
        input  stall, branch_taken, branch_target, trap_req, trap_vector, halt_req, resume,
        output stage, stage_oh, pc, wb_en, retire, misaligned, halted, instret, cycles
    );

    modport slave (
        output stall, branch_taken, branch_target, trap_req, trap_vector, halt_req, resume,
        input  stage, stage_oh, pc, wb_en, retire, misaligned, halted, instret, cycles
    );
endinterface

// File: rtl/core_seq.sv
// core_seq: multi-cycle sequencer owning the PC, stage counter, halt state and retire/cycle counters
module core_seq #(
    parameter int              XLEN       = 32,
    parameter int              NUM_STAGES = 5,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              PC_STEP    = 4,
    parameter int              CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    core_seq_if.master bus
);
    typedef enum logic {RUN, HALTED} state_t;

    localparam logic [2:0] LAST = 3'(NUM_STAGES - 1);

    state_t           state_q, state_d;
    logic [2:0]       stage_q, stage_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             retire_q, misaligned_q;
    logic             commit, mis_c;

    // A writeback stage that is not stalled commits this cycle; redirect inputs matter only here
    assign commit = (state_q == RUN) && (stage_q == LAST) && !bus.stall;
    assign mis_c  = commit && !bus.trap_req && bus.branch_taken && |bus.branch_target[1:0];

    // Next state: stage advance, commit-time PC selection and halt entry, resume from HALTED
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        cycles_d  = cycles_q;
        if (state_q == HALTED) begin
            state_d = bus.resume ? RUN : HALTED;
        end else begin
            cycles_d = cycles_q + CNT_W'(1);
            if (commit) begin
                stage_d   = '0;
                instret_d = instret_q + CNT_W'(1);
                state_d   = bus.halt_req ? HALTED : RUN;
                pc_d      = (bus.trap_req || mis_c) ? bus.trap_vector :
                            bus.branch_taken        ? bus.branch_target :
                                                      pc_q + XLEN'(PC_STEP);
            end else begin
                stage_d = bus.stall ? stage_q : stage_q + 3'd1;
            end
        end
    end

    // State, PC and counters; reset abandons the instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            stage_q      <= '0;
            pc_q         <= RESET_PC;
            instret_q    <= '0;
            cycles_q     <= '0;
            retire_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            pc_q         <= pc_d;
            instret_q    <= instret_d;
            cycles_q     <= cycles_d;
            retire_q     <= commit;
            misaligned_q <= mis_c;
        end
    end

    assign bus.stage      = stage_q;
    assign bus.stage_oh   = (state_q == HALTED) ? '0 : NUM_STAGES'(1) << stage_q;
    assign bus.pc         = pc_q;
    assign bus.wb_en      = commit;
    assign bus.retire     = retire_q;
    assign bus.misaligned = misaligned_q;
    assign bus.halted     = (state_q == HALTED);
    assign bus.instret    = instret_q;
    assign bus.cycles     = cycles_q;
endmodule
